// File: rtl/systolic_matmul_engine_pkg.sv
// rtl/systolic_matmul_engine_pkg.sv - shared types and operand extension for the systolic matmul engine
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int OP_W_MAX = 32;
  localparam int OP_IDX_W = $clog2(OP_W_MAX);

  // val must arrive zero-extended above width; returns it sign- or zero-extended to 2*OP_W_MAX
  function automatic logic [2*OP_W_MAX-1:0] ext_operand(input logic [OP_W_MAX-1:0] val,
                                                        input int width,
                                                        input logic signed_mode);
    logic [2*OP_W_MAX-1:0] ext;
    ext = {{OP_W_MAX{1'b0}}, val};
    if (signed_mode && val[OP_IDX_W'(width - 1)]) begin
      ext = ext | ({(2*OP_W_MAX){1'b1}} << width);
    end
    return ext;
  endfunction

endpackage

// File: rtl/systolic_matmul_engine_if.sv
// rtl/systolic_matmul_engine_if.sv - job control, operand beat and result row signals of the matmul engine
interface systolic_matmul_engine_if #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ACC_W  = 24,
  parameter int MAX_K  = 64
);
  localparam int KW = $clog2(MAX_K + 1);
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                   start;
  logic [KW-1:0]          k_len;
  logic                   signed_mode;
  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] a_vec;
  logic [COLS*DATA_W-1:0] b_vec;
  logic                   out_valid;
  logic                   out_ready;
  logic [COLS*ACC_W-1:0]  out_row;
  logic [IW-1:0]          out_row_idx;
  logic                   busy;
  logic                   done;

  modport slave (
    input  start, k_len, signed_mode, in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, busy, done
  );

  modport master (
    output start, k_len, signed_mode, in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, busy, done
  );

endinterface

// File: rtl/systolic_matmul_engine_mac_pe.sv
// rtl/systolic_matmul_engine_mac_pe.sv - one output-stationary PE: forwards a right and b down, accumulates a*b
module mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vld_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vld_out,
  output logic [ACC_W-1:0]  acc
);

  logic [2*OP_W_MAX-1:0] a_full;
  logic [2*OP_W_MAX-1:0] b_full;
  logic [ACC_W-1:0]      prod;

  // Low ACC_W bits of the wide extended product equal the extended 2*DATA_W product mod 2^ACC_W
  always_comb begin
    a_full = ext_operand(OP_W_MAX'(a_in), DATA_W, signed_mode);
    b_full = ext_operand(OP_W_MAX'(b_in), DATA_W, signed_mode);
    prod   = ACC_W'(a_full * b_full);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      b_out     <= '0;
      b_vld_out <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      b_out     <= b_in;
      b_vld_out <= b_vld_in;
      if (clear) begin
        acc <= '0;
      end else if (a_vld_in && b_vld_in) begin
        acc <= acc + prod;
      end
    end
  end

endmodule

// File: rtl/systolic_matmul_engine.sv
// rtl/systolic_matmul_engine.sv - ROWS x COLS output-stationary systolic matmul with input skew and row-serial readout
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ACC_W  = 24,
  parameter int MAX_K  = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  systolic_matmul_engine_if.slave bus
);

  localparam int KW        = $clog2(MAX_K + 1);
  localparam int IW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FLUSH_CYC = ROWS + COLS;
  localparam int FW        = $clog2(FLUSH_CYC + 1);

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] k_q;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic [IW-1:0] row_idx;
  logic          sm_q;
  logic          done_q;
  logic          beat;
  logic          last_beat;
  logic          flush_end;
  logic          row_acc;
  logic          last_row_acc;
  logic          clear;

  logic [DATA_W-1:0] a_h  [ROWS][COLS+1];
  logic              a_hv [ROWS][COLS+1];
  logic [DATA_W-1:0] b_v  [ROWS+1][COLS];
  logic              b_vv [ROWS+1][COLS];
  logic [ACC_W-1:0]  acc  [ROWS][COLS];

  assign beat         = (state == LOAD) && bus.in_valid;
  assign last_beat    = beat && (beat_cnt == k_q - KW'(1));
  assign flush_end    = (state == FLUSH) && (flush_cnt == FW'(FLUSH_CYC - 1));
  assign row_acc      = (state == DRAIN) && bus.out_ready;
  assign last_row_acc = row_acc && (row_idx == IW'(ROWS - 1));
  assign clear        = (state == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start)    state_nxt = LOAD;
      LOAD:    if (last_beat)    state_nxt = FLUSH;
      FLUSH:   if (flush_end)    state_nxt = DRAIN;
      DRAIN:   if (last_row_acc) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = (state == LOAD);
    bus.out_valid   = (state == DRAIN);
    bus.busy        = (state != IDLE);
    bus.done        = done_q;
    bus.out_row_idx = row_idx;
  end

  // FLUSH lasts one cycle past the final accumulate so DRAIN sees settled accumulators
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q       <= KW'(1);
      sm_q      <= 1'b0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_idx   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= last_row_acc;
      flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
      if (clear) begin
        k_q      <= (bus.k_len == '0) ? KW'(1) : bus.k_len;
        sm_q     <= bus.signed_mode;
        beat_cnt <= '0;
        row_idx  <= '0;
      end
      if (beat) begin
        beat_cnt <= beat_cnt + KW'(1);
      end
      if (row_acc) begin
        row_idx <= last_row_acc ? '0 : row_idx + IW'(1);
      end
    end
  end

  // Row r of A passes through r+1 registers, column c of B through c+1; bubbles travel as zero/invalid
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic [DATA_W-1:0] sd [r+1];
    logic              sv [r+1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int j = 0; j <= r; j++) begin
          sd[j] <= '0;
          sv[j] <= 1'b0;
        end
      end else begin
        sd[0] <= beat ? bus.a_vec[r*DATA_W +: DATA_W] : '0;
        sv[0] <= beat;
        for (int j = 1; j <= r; j++) begin
          sd[j] <= sd[j-1];
          sv[j] <= sv[j-1];
        end
      end
    end
    assign a_h[r][0]  = sd[r];
    assign a_hv[r][0] = sv[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic [DATA_W-1:0] sd [c+1];
    logic              sv [c+1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int j = 0; j <= c; j++) begin
          sd[j] <= '0;
          sv[j] <= 1'b0;
        end
      end else begin
        sd[0] <= beat ? bus.b_vec[c*DATA_W +: DATA_W] : '0;
        sv[0] <= beat;
        for (int j = 1; j <= c; j++) begin
          sd[j] <= sd[j-1];
          sv[j] <= sv[j-1];
        end
      end
    end
    assign b_v[0][c]  = sd[c];
    assign b_vv[0][c] = sv[c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .signed_mode (sm_q),
        .a_in        (a_h[r][c]),
        .a_vld_in    (a_hv[r][c]),
        .b_in        (b_v[r][c]),
        .b_vld_in    (b_vv[r][c]),
        .a_out       (a_h[r][c+1]),
        .a_vld_out   (a_hv[r][c+1]),
        .b_out       (b_v[r+1][c]),
        .b_vld_out   (b_vv[r+1][c]),
        .acc         (acc[r][c])
      );
    end
  end

  always_comb begin
    bus.out_row = '0;
    for (int c = 0; c < COLS; c++) begin
      bus.out_row[c*ACC_W +: ACC_W] = acc[row_idx][c];
    end
  end

endmodule
